// File: rtl/fetch_unit.sv
// Fetch stage: owns the PC, issues paired instruction-memory reads and buffers
// {pc,instr} entries in an in-order queue that offers up to two per cycle to decode.
module fetch_unit #(
  parameter int              PC_W     = 16,
  parameter int              INSTR_W  = 32,
  parameter int              QDEPTH   = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [PC_W-1:0]      branchpc,
  input  logic                 isbranchtaken,
  output logic                 imem_req,
  output logic [PC_W-1:0]      imem_addr,
  input  logic                 imem_valid,
  input  logic [2*INSTR_W-1:0] imem_rdata,
  output logic                 out_valid0,
  output logic [PC_W-1:0]      out_pc0,
  output logic [INSTR_W-1:0]   out_instr0,
  output logic                 out_valid1,
  output logic [PC_W-1:0]      out_pc1,
  output logic [INSTR_W-1:0]   out_instr1,
  input  logic [1:0]           dec_take
);

  localparam int PTR_W = $clog2(QDEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] ISSUE_MAX = (CNT_W+1)'(QDEPTH - 2);

  logic [PC_W-1:0]    pc_q    [QDEPTH];
  logic [INSTR_W-1:0] instr_q [QDEPTH];

  logic [PTR_W-1:0] head, tail, head_p1, tail_p1;
  logic [CNT_W-1:0] count;
  logic [PC_W-1:0]  pc, pc_p1, pc_p2;
  logic             outstanding, squash, run;

  logic [1:0]       take, deq;
  logic [CNT_W:0]   occ;
  logic             resp, enq;

  assign head_p1 = head + PTR_W'(1);
  assign tail_p1 = tail + PTR_W'(1);
  assign pc_p1   = pc + PC_W'(1);
  assign pc_p2   = pc + PC_W'(2);

  // occ is the fill level after this edge; room for a full pair is reserved at
  // issue time so a response can always be enqueued.
  always_comb begin
    take = (dec_take == 2'd3) ? 2'd2 : dec_take;
    deq  = take;
    if ({{(CNT_W-2){1'b0}}, take} > count) deq = count[1:0];
    resp = imem_valid & outstanding;
    enq  = resp & ~squash & ~isbranchtaken;
    occ  = {1'b0, count} - {{(CNT_W-1){1'b0}}, deq} + {{(CNT_W-1){1'b0}}, enq, 1'b0};
    imem_req  = run & (~outstanding | resp) & ~isbranchtaken & (occ <= ISSUE_MAX);
    imem_addr = enq ? pc_p2 : pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      head        <= '0;
      tail        <= '0;
      count       <= '0;
      outstanding <= 1'b0;
      squash      <= 1'b0;
      run         <= 1'b0;
    end else begin
      run <= 1'b1;
      if (isbranchtaken) begin
        pc          <= branchpc;
        head        <= '0;
        tail        <= '0;
        count       <= '0;
        // a read still in flight after this edge returns stale data
        outstanding <= outstanding & ~imem_valid;
        squash      <= outstanding & ~imem_valid;
      end else begin
        head  <= head + PTR_W'(deq);
        count <= occ[CNT_W-1:0];
        if (enq) begin
          tail <= tail + PTR_W'(2);
          pc   <= pc_p2;
        end
        if (resp) begin
          outstanding <= 1'b0;
          squash      <= 1'b0;
        end
        if (imem_req) outstanding <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      pc_q[tail]       <= pc;
      instr_q[tail]    <= imem_rdata[INSTR_W-1:0];
      pc_q[tail_p1]    <= pc_p1;
      instr_q[tail_p1] <= imem_rdata[2*INSTR_W-1:INSTR_W];
    end
  end

  assign out_valid0 = (count != '0);
  assign out_valid1 = (count[CNT_W-1:1] != '0);
  assign out_pc0    = pc_q[head];
  assign out_instr0 = instr_q[head];
  assign out_pc1    = pc_q[head_p1];
  assign out_instr1 = instr_q[head_p1];

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: behavioural imem with programmable latency,
// one task per scenario with inline expected-value comparisons.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] branchpc = '0;
  logic        isbranchtaken = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_valid = 1'b0;
  logic [63:0] imem_rdata = '0;
  logic        out_valid0, out_valid1;
  logic [15:0] out_pc0, out_pc1;
  logic [31:0] out_instr0, out_instr1;
  logic [1:0]  dec_take = 2'd0;

  int errors = 0;
  int checks = 0;
  int lat = 1;
  logic [15:0] req_log[$];
  logic        mem_busy = 1'b0;
  int          mem_cnt = 0;
  logic [15:0] mem_addr = '0;

  fetch_unit dut (
    .clk(clk), .rst_n(rst_n), .branchpc(branchpc), .isbranchtaken(isbranchtaken),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid),
    .imem_rdata(imem_rdata), .out_valid0(out_valid0), .out_pc0(out_pc0),
    .out_instr0(out_instr0), .out_valid1(out_valid1), .out_pc1(out_pc1),
    .out_instr1(out_instr1), .dec_take(dec_take)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [15:0] a);
    return {16'hC0DE, a};
  endfunction

  // imem: response driven at negedge, request sampled 1 unit before posedge
  initial begin
    forever begin
      @(negedge clk);
      imem_valid = 1'b0;
      if (mem_busy && rst_n) begin
        mem_cnt--;
        if (mem_cnt == 0) begin
          imem_valid = 1'b1;
          imem_rdata = {mk(mem_addr + 16'd1), mk(mem_addr)};
          mem_busy   = 1'b0;
        end
      end
      #4;
      if (!rst_n) mem_busy = 1'b0;
      else if (imem_req) begin
        mem_busy = 1'b1;
        mem_cnt  = lat;
        mem_addr = imem_addr;
        req_log.push_back(imem_addr);
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; isbranchtaken = 1'b0; dec_take = 2'd0; branchpc = '0;
    step(); step();
    req_log.delete();
    rst_n = 1'b1;
  endtask

  task automatic wait_valid(input string name, input int max);
    int n = 0;
    while (!out_valid0 && n < max) begin step(); n++; end
    checks++; if (out_valid0 !== 1'b1) begin errors++; $display("FAIL %s timeout valid0=%b exp=1", name, out_valid0); end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; lat = 1;
    step(); step();
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%b exp=0", imem_req); end
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL rst_v0 got=%b exp=0", out_valid0); end
    checks++; if (out_valid1 !== 1'b0) begin errors++; $display("FAIL rst_v1 got=%b exp=0", out_valid1); end
    req_log.delete();
    rst_n = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1) begin errors++; $display("FAIL first_req got=%b exp=1", imem_req); end
    checks++; if (imem_addr !== 16'h0000) begin errors++; $display("FAIL first_addr got=%h exp=0000", imem_addr); end
  endtask

  task automatic test_fill();
    logic [15:0] exp_addr [4];
    exp_addr = '{16'h0000, 16'h0002, 16'h0004, 16'h0006};
    repeat (20) step();
    checks++; if (req_log.size() !== 4) begin errors++; $display("FAIL fill_nreq got=%0d exp=4", req_log.size()); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (req_log[i] !== exp_addr[i]) begin errors++; $display("FAIL fill_addr%0d got=%h exp=%h", i, req_log[i], exp_addr[i]); end
    end
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL full_req got=%b exp=0", imem_req); end
    checks++; if (out_valid0 !== 1'b1 || out_valid1 !== 1'b1) begin errors++; $display("FAIL fill_valid got=%b%b exp=11", out_valid0, out_valid1); end
    checks++; if (out_pc0 !== 16'h0000 || out_pc1 !== 16'h0001) begin errors++; $display("FAIL fill_pc got=%h/%h exp=0000/0001", out_pc0, out_pc1); end
    checks++; if (out_instr1 !== 32'hC0DE0001) begin errors++; $display("FAIL fill_instr1 got=%h exp=c0de0001", out_instr1); end
  endtask

  task automatic test_full_drain();
    int takes [6];
    logic [15:0] exp_pc;
    takes = '{2, 1, 2, 2, 1, 2};
    dec_take = 2'd2; #1;
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0008) begin errors++; $display("FAIL drain_req got=%b/%h exp=1/0008", imem_req, imem_addr); end
    step(); dec_take = 2'd0;
    checks++; if (out_pc0 !== 16'h0002 || out_pc1 !== 16'h0003) begin errors++; $display("FAIL drain_pc got=%h/%h exp=0002/0003", out_pc0, out_pc1); end
    step(); step();
    exp_pc = 16'h0002;
    for (int i = 0; i < 6; i++) begin
      checks++; if (out_valid0 !== 1'b1 || out_valid1 !== 1'b1 || out_pc0 !== exp_pc || out_pc1 !== exp_pc + 16'd1)
        begin errors++; $display("FAIL stream%0d got=%b%b %h/%h exp=11 %h/%h", i, out_valid0, out_valid1, out_pc0, out_pc1, exp_pc, exp_pc + 16'd1); end
      checks++; if (out_instr0 !== mk(exp_pc)) begin errors++; $display("FAIL stream_instr%0d got=%h exp=%h", i, out_instr0, mk(exp_pc)); end
      dec_take = 2'(takes[i]);
      step();
      exp_pc = exp_pc + 16'(takes[i]);
    end
    dec_take = 2'd0;
  endtask

  task automatic test_redirect_outstanding();
    lat = 3; do_reset();
    step(); step();
    branchpc = 16'h1234; isbranchtaken = 1'b1; #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL t3_req got=%b exp=0", imem_req); end
    step(); isbranchtaken = 1'b0;
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL t3_empty got=%b exp=0", out_valid0); end
    wait_valid("t3_wait", 30);
    checks++; if (out_pc0 !== 16'h1234 || out_pc1 !== 16'h1235) begin errors++; $display("FAIL t3_pc got=%h/%h exp=1234/1235", out_pc0, out_pc1); end
    checks++; if (out_instr0 !== 32'hC0DE1234) begin errors++; $display("FAIL t3_instr got=%h exp=c0de1234", out_instr0); end
    checks++; if (req_log[1] !== 16'h1234) begin errors++; $display("FAIL t3_addr got=%h exp=1234", req_log[1]); end
  endtask

  task automatic test_redirect_with_response();
    lat = 1; do_reset();
    step(); step();
    dec_take = 2'd2; branchpc = 16'h0040; isbranchtaken = 1'b1; #1;
    checks++; if (imem_req !== 1'b0) begin errors++; $display("FAIL t4_req got=%b exp=0", imem_req); end
    step(); isbranchtaken = 1'b0; dec_take = 2'd0; #1;
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL t4_empty got=%b exp=0", out_valid0); end
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin errors++; $display("FAIL t4_reissue got=%b/%h exp=1/0040", imem_req, imem_addr); end
    wait_valid("t4_wait", 20);
    checks++; if (out_pc0 !== 16'h0040 || out_instr1 !== 32'hC0DE0041) begin errors++; $display("FAIL t4_data got=%h/%h exp=0040/c0de0041", out_pc0, out_instr1); end
  endtask

  task automatic test_wrap();
    lat = 1; do_reset();
    step();
    branchpc = 16'hFFFF; isbranchtaken = 1'b1;
    step(); isbranchtaken = 1'b0;
    wait_valid("t5_wait", 20);
    checks++; if (out_pc0 !== 16'hFFFF || out_pc1 !== 16'h0000) begin errors++; $display("FAIL t5_pc got=%h/%h exp=ffff/0000", out_pc0, out_pc1); end
    checks++; if (out_instr1 !== 32'hC0DE0000) begin errors++; $display("FAIL t5_instr1 got=%h exp=c0de0000", out_instr1); end
    step();
    checks++; if (req_log[0] !== 16'hFFFF || req_log[1] !== 16'h0001) begin errors++; $display("FAIL t5_addr got=%h,%h exp=ffff,0001", req_log[0], req_log[1]); end
  endtask

  task automatic test_underflow_and_reset();
    lat = 5; do_reset();
    step();
    wait_valid("t6_wait", 20);
    dec_take = 2'd1;
    step(); dec_take = 2'd0;
    checks++; if (out_valid0 !== 1'b1 || out_valid1 !== 1'b0 || out_pc0 !== 16'h0001)
      begin errors++; $display("FAIL t6_one got=%b%b %h exp=10 0001", out_valid0, out_valid1, out_pc0); end
    dec_take = 2'd2;
    step(); dec_take = 2'd0;
    checks++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin errors++; $display("FAIL t6_clamp got=%b%b exp=00", out_valid0, out_valid1); end
    dec_take = 2'd2;
    step(); dec_take = 2'd0;
    checks++; if (out_valid0 !== 1'b0) begin errors++; $display("FAIL t6_empty_take got=%b exp=0", out_valid0); end
    wait_valid("t6_refill", 20);
    checks++; if (out_pc0 !== 16'h0002 || out_pc1 !== 16'h0003) begin errors++; $display("FAIL t6_refill_pc got=%h/%h exp=0002/0003", out_pc0, out_pc1); end
    rst_n = 1'b0; #1;
    checks++; if (imem_req !== 1'b0 || out_valid0 !== 1'b0 || out_valid1 !== 1'b0 || imem_addr !== 16'h0000)
      begin errors++; $display("FAIL t6_rst got=%b%b%b %h exp=000 0000", imem_req, out_valid0, out_valid1, imem_addr); end
    step(); req_log.delete(); rst_n = 1'b1;
    step();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 16'h0000) begin errors++; $display("FAIL t6_restart got=%b/%h exp=1/0000", imem_req, imem_addr); end
    wait_valid("t6_restart_wait", 20);
    checks++; if (out_pc0 !== 16'h0000 || out_instr0 !== 32'hC0DE0000) begin errors++; $display("FAIL t6_restart_pc got=%h/%h exp=0000/c0de0000", out_pc0, out_instr0); end
  endtask

  initial begin
    test_reset();
    test_fill();
    test_full_drain();
    test_redirect_outstanding();
    test_redirect_with_response();
    test_wrap();
    test_underflow_and_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
